i2c_master_ctrl: RTL and testbench

Byte-level I2C master sequencer that owns one master port of the I2C channel and generates START, byte write, byte read and STOP conditions from a simple command handshake. It drives SCL/SDA open-drain style (pull-low enables only; the channel provides the pull-ups). It samples the wired bus for ACK, read data, clock stretching and arbitration loss, and sits between the processor-side register block and the channel's master port.

---
 rtl/i2c_master_ctrl_if.sv | 32 +++
 rtl/i2c_master_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_ctrl_if.sv
// Command/response handshake and open-drain bus pins of one I2C master port.
interface i2c_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       cmd_nack;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_ack;
    logic       rsp_err;
    logic       arb_lost;
    logic       busy;
    logic       scl_i;
    logic       sda_i;
    logic       scl_oe;
    logic       sda_oe;

    // Controller side: takes commands and bus levels, drives responses and pull-downs.
    modport master (
        input  cmd_valid, cmd_op, cmd_wdata, cmd_nack, scl_i, sda_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_ack, rsp_err, arb_lost, busy,
        scl_oe, sda_oe
    );

    // Register-block / channel side.
    modport slave (
        output cmd_valid, cmd_op, cmd_wdata, cmd_nack, scl_i, sda_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_ack, rsp_err, arb_lost, busy,
        scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master sequencer: START / WRITE / READ / STOP from a command handshake,
// open-drain outputs, clock-stretch and arbitration-loss handling.
module i2c_master_ctrl #(
    parameter int unsigned PRESCALE = 125
) (
    input  logic              pclk,
    input  logic              presetn,
    i2c_master_ctrl_if.master bus
);

    localparam int unsigned   CW       = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HOLD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_BIT   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    logic [2:0]    state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    op_q, op_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          nack_q, nack_d;
    logic          ackbit_q, ackbit_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_ack_q, rsp_ack_d;
    logic          rsp_err_q, rsp_err_d;
    logic          arb_lost_q, arb_lost_d;
    logic          scl_oe_q, scl_oe_d;
    logic          sda_oe_q, sda_oe_d;
    logic [1:0]    scl_sync_q, scl_sync_d;
    logic [1:0]    sda_sync_q, sda_sync_d;

    logic scl_s, sda_s;
    logic cmd_ready;
    logic accept;
    logic active;
    logic stall;
    logic arb_hit;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign accept    = bus.cmd_valid && cmd_ready;
    assign active    = (state_q == ST_START) || (state_q == ST_BIT) || (state_q == ST_STOP);

    // Stretch: a released SCL that still reads low keeps Q1 from ending and freezes Q2.
    // Q1 only waits at its last count so the synchronizer lag costs no time on a free bus.
    assign stall = active && !scl_oe_q && !scl_s &&
                   (((phase_q == 2'd1) && (cnt_q == CNT_LAST)) || (phase_q == 2'd2));

    // Two-flop synchronizers for the wired bus levels.
    always_comb begin
        scl_sync_d = {scl_sync_q[0], bus.scl_i};
        sda_sync_d = {sda_sync_q[0], bus.sda_i};
    end

    // Sequencer next state: command accept, quarter timing, bit sampling and responses.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        op_d        = op_q;
        shreg_d     = shreg_q;
        nack_d      = nack_q;
        ackbit_d    = ackbit_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_ack_d   = 1'b0;
        rsp_err_d   = 1'b0;
        arb_lost_d  = 1'b0;
        arb_hit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.cmd_op == OP_START) begin
                        state_d = ST_START;
                        phase_d = 2'd0;
                        cnt_d   = '0;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    phase_d = 2'd0;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    case (bus.cmd_op)
                        OP_START: state_d = ST_START;
                        OP_WRITE: begin
                            state_d = ST_BIT;
                            op_d    = OP_WRITE;
                            shreg_d = bus.cmd_wdata;
                        end
                        OP_READ: begin
                            state_d = ST_BIT;
                            op_d    = OP_READ;
                            shreg_d = 8'h00;
                            nack_d  = bus.cmd_nack;
                        end
                        default: state_d = ST_STOP;
                    endcase
                end
            end
            ST_START, ST_BIT, ST_STOP: begin
                if (!stall) begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d   = '0;
                        phase_d = phase_q + 2'd1;
                        case (state_q)
                            ST_START: begin
                                // Someone else holds SDA low while we expect a free bus.
                                if ((phase_q == 2'd1) && !sda_s) begin
                                    arb_hit = 1'b1;
                                end else if (phase_q == 2'd3) begin
                                    state_d     = ST_HOLD;
                                    busy_d      = 1'b1;
                                    rsp_valid_d = 1'b1;
                                end
                            end
                            ST_BIT: begin
                                if (phase_q == 2'd2) begin
                                    if (bit_q == 4'd8) begin
                                        ackbit_d = !sda_s;
                                    end else if (op_q == OP_READ) begin
                                        shreg_d = {shreg_q[6:0], sda_s};
                                    end else if (shreg_q[7] && !sda_s) begin
                                        arb_hit = 1'b1;
                                    end
                                end else if (phase_q == 2'd3) begin
                                    if (bit_q == 4'd8) begin
                                        state_d     = ST_HOLD;
                                        rsp_valid_d = 1'b1;
                                        rsp_ack_d   = (op_q == OP_WRITE) && ackbit_q;
                                        if (op_q == OP_READ) begin
                                            rdata_d = shreg_q;
                                        end
                                    end else begin
                                        bit_d = bit_q + 4'd1;
                                        if (op_q == OP_WRITE) begin
                                            shreg_d = {shreg_q[6:0], 1'b0};
                                        end
                                    end
                                end
                            end
                            default: begin
                                if (phase_q == 2'd3) begin
                                    state_d     = ST_IDLE;
                                    busy_d      = 1'b0;
                                    rsp_valid_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (arb_hit) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            rsp_valid_d = 1'b1;
            arb_lost_d  = 1'b1;
        end
    end

    // Pull-down enables for the upcoming cycle, derived from the next phase so the
    // registered outputs line up with the quarter they belong to.
    always_comb begin
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
        case (state_d)
            ST_IDLE: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
            ST_START: begin
                case (phase_d)
                    2'd0:    sda_oe_d = 1'b0;
                    2'd1:    scl_oe_d = 1'b0;
                    2'd2:    sda_oe_d = 1'b1;
                    default: scl_oe_d = 1'b1;
                endcase
            end
            ST_BIT: begin
                case (phase_d)
                    2'd0: begin
                        scl_oe_d = 1'b1;
                        if (bit_d == 4'd8) begin
                            sda_oe_d = (op_d == OP_READ) && !nack_d;
                        end else begin
                            sda_oe_d = (op_d == OP_WRITE) && !shreg_d[7];
                        end
                    end
                    2'd1:    scl_oe_d = 1'b0;
                    2'd3:    scl_oe_d = 1'b1;
                    default: ;
                endcase
            end
            ST_STOP: begin
                case (phase_d)
                    2'd0: begin
                        scl_oe_d = 1'b1;
                        sda_oe_d = 1'b1;
                    end
                    2'd1:    scl_oe_d = 1'b0;
                    2'd3:    sda_oe_d = 1'b0;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // State registers; reset releases both lines without waiting for a clock.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            phase_q     <= 2'd0;
            cnt_q       <= '0;
            bit_q       <= 4'd0;
            op_q        <= OP_START;
            shreg_q     <= 8'h00;
            nack_q      <= 1'b0;
            ackbit_q    <= 1'b0;
            rdata_q     <= 8'h00;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ack_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            arb_lost_q  <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            op_q        <= op_d;
            shreg_q     <= shreg_d;
            nack_q      <= nack_d;
            ackbit_q    <= ackbit_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ack_q   <= rsp_ack_d;
            rsp_err_q   <= rsp_err_d;
            arb_lost_q  <= arb_lost_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_ack   = rsp_ack_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.arb_lost  = arb_lost_q;
    assign bus.busy      = busy_q;
    assign bus.scl_oe    = scl_oe_q;
    assign bus.sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: pull-up bus, scripted slave, stretch and second master.
module tb_i2c_master_ctrl;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    logic pclk;
    logic presetn;

    i2c_master_ctrl_if bus_if ();

    i2c_master_ctrl #(.PRESCALE(4)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus_if.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Bus model state.
    logic       slv_scl_low = 1'b0;
    logic       slv_ack     = 1'b0;
    logic [7:0] slv_byte    = 8'h00;
    logic       xfer_wr     = 1'b0;
    logic       xfer_rd     = 1'b0;
    logic       arb_en      = 1'b0;
    logic       slave_sda_low;
    logic       m2_sda_low;
    logic       scl_line;
    logic       sda_line;
    int         nfall       = 0;
    int         nf_base     = 0;
    int         bidx;
    logic [8:0] cap         = 9'h000;
    int         cyc         = 0;
    int         acc_cyc     = 0;
    int         sda8_hits   = 0;
    int         b8_cycles   = 0;

    assign scl_line     = !(bus_if.scl_oe || slv_scl_low);
    assign sda_line     = !(bus_if.sda_oe || slave_sda_low || m2_sda_low);
    assign bus_if.scl_i = scl_line;
    assign bus_if.sda_i = sda_line;
    assign bidx         = nfall - nf_base;
    assign m2_sda_low   = arb_en && xfer_wr && (bidx == 7);

    // Slave: read data while bidx<8, ACK on the 9th bit of a write.
    always_comb begin
        logic [2:0] sel;
        slave_sda_low = 1'b0;
        sel = 3'(7 - bidx);
        if (xfer_rd && bidx >= 0 && bidx < 8) slave_sda_low = !slv_byte[sel];
        if (xfer_wr && slv_ack && bidx == 8) slave_sda_low = 1'b1;
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;
    always @(negedge scl_line) nfall <= nfall + 1;
    always @(posedge scl_line) cap <= {cap[7:0], sda_line};

    // Watch the master's SDA drive during the 9th bit of a read.
    always @(posedge pclk) begin
        if (xfer_rd && bidx == 8) begin
            b8_cycles <= b8_cycles + 1;
            if (bus_if.sda_oe) sda8_hits <= sda8_hits + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer a command at #1 after an edge; returns #1 after the accepting edge.
    task automatic issue(input string tag, input logic [1:0] op, input logic [7:0] wd,
                         input logic nk);
        check({tag, "_ready"}, 32'(bus_if.cmd_ready), 1);
        bus_if.cmd_op    = op;
        bus_if.cmd_wdata = wd;
        bus_if.cmd_nack  = nk;
        bus_if.cmd_valid = 1'b1;
        @(posedge pclk);
        #1;
        bus_if.cmd_valid = 1'b0;
        acc_cyc = cyc;
        nf_base = nfall;
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        int n;
        n = 0;
        while (!bus_if.rsp_valid && n < 400) begin
            @(posedge pclk);
            #1;
            n++;
        end
        check({tag, "_rsp"}, 32'(bus_if.rsp_valid), 1);
        lat = cyc - acc_cyc;
    endtask

    task automatic do_cmd(input string tag, input logic [1:0] op, input int exp_lat);
        int lat;
        issue(tag, op, 8'h00, 1'b0);
        wait_rsp(tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(bus_if.rsp_err), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(bus_if.cmd_ready), 1);
        check({tag, "_rvalid"}, 32'(bus_if.rsp_valid), 0);
        check({tag, "_rdata"}, 32'(bus_if.rsp_rdata), 0);
        check({tag, "_ack"}, 32'(bus_if.rsp_ack), 0);
        check({tag, "_err"}, 32'(bus_if.rsp_err), 0);
        check({tag, "_arb"}, 32'(bus_if.arb_lost), 0);
        check({tag, "_busy"}, 32'(bus_if.busy), 0);
        check({tag, "_scl_oe"}, 32'(bus_if.scl_oe), 0);
        check({tag, "_sda_oe"}, 32'(bus_if.sda_oe), 0);
    endtask

    initial begin
        int lat;
        int h0;
        int b0;
        int n;
        presetn          = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 2'b00;
        bus_if.cmd_wdata = 8'h00;
        bus_if.cmd_nack  = 1'b0;
        #2;
        check_reset_vals("rst");
        #20;
        presetn = 1'b1;
        @(posedge pclk);
        #1;

        // Write 0xA5 to an acking slave.
        do_cmd("t1_start", OP_START, 16);
        check("t1_busy_on", 32'(bus_if.busy), 1);
        check("t1_scl_held", 32'(bus_if.scl_oe), 1);
        slv_ack = 1'b1;
        issue("t1_wr", OP_WRITE, 8'hA5, 1'b0);
        xfer_wr = 1'b1;
        wait_rsp("t1_wr", lat);
        xfer_wr = 1'b0;
        check("t1_wr_lat", 32'(lat), 144);
        check("t1_wr_ack", 32'(bus_if.rsp_ack), 1);
        check("t1_wr_bits", 32'(cap), 32'h14A);
        check("t1_wr_arb", 32'(bus_if.arb_lost), 0);
        do_cmd("t1_stop", OP_STOP, 16);
        check("t1_busy_off", 32'(bus_if.busy), 0);
        check("t1_lines_rel", 32'({bus_if.scl_oe, bus_if.sda_oe}), 0);

        // Read 0x3C, NACK the byte.
        do_cmd("t2_start", OP_START, 16);
        slv_byte = 8'h3C;
        h0 = sda8_hits;
        b0 = b8_cycles;
        issue("t2_rd", OP_READ, 8'h00, 1'b1);
        xfer_rd = 1'b1;
        wait_rsp("t2_rd", lat);
        xfer_rd = 1'b0;
        check("t2_rd_lat", 32'(lat), 144);
        check("t2_rd_data", 32'(bus_if.rsp_rdata), 32'h3C);
        check("t2_rd_ack", 32'(bus_if.rsp_ack), 0);
        check("t2_rd_bits", 32'(cap), 32'h079);
        check("t2_nack_rel", 32'(sda8_hits - h0), 0);
        check("t2_b8_seen", 32'(b8_cycles > b0), 1);
        do_cmd("t2_stop", OP_STOP, 16);
        check("t2_busy_off", 32'(bus_if.busy), 0);

        // Absent slave: no ACK.
        slv_ack = 1'b0;
        do_cmd("t3_start", OP_START, 16);
        issue("t3_wr", OP_WRITE, 8'h90, 1'b0);
        xfer_wr = 1'b1;
        wait_rsp("t3_wr", lat);
        xfer_wr = 1'b0;
        check("t3_wr_ack", 32'(bus_if.rsp_ack), 0);
        check("t3_wr_bits", 32'(cap), 32'h121);
        do_cmd("t3_stop", OP_STOP, 16);
        check("t3_busy_off", 32'(bus_if.busy), 0);

        // Slave stretches SCL through bit 3 of 0x5A.
        slv_ack = 1'b1;
        do_cmd("t4_start", OP_START, 16);
        issue("t4_wr", OP_WRITE, 8'h5A, 1'b0);
        xfer_wr = 1'b1;
        n = 0;
        while (bidx != 3 && n < 200) begin
            @(posedge pclk);
            #1;
            n++;
        end
        check("t4_bit3_seen", 32'(bidx), 3);
        slv_scl_low = 1'b1;
        repeat (28) @(posedge pclk);
        #1;
        slv_scl_low = 1'b0;
        wait_rsp("t4_wr", lat);
        xfer_wr = 1'b0;
        check("t4_wr_lat", 32'(lat), 163);
        check("t4_wr_bits", 32'(cap), 32'h0B4);
        check("t4_wr_ack", 32'(bus_if.rsp_ack), 1);
        check("t4_wr_arb", 32'(bus_if.arb_lost), 0);
        do_cmd("t4_stop", OP_STOP, 16);

        // Second master pulls SDA low on bit 7 of 0xFF.
        do_cmd("t5_start", OP_START, 16);
        arb_en = 1'b1;
        issue("t5_wr", OP_WRITE, 8'hFF, 1'b0);
        xfer_wr = 1'b1;
        wait_rsp("t5_wr", lat);
        check("t5_arb_lat", 32'(lat), 124);
        check("t5_arb_lost", 32'(bus_if.arb_lost), 1);
        check("t5_lines_rel", 32'({bus_if.scl_oe, bus_if.sda_oe}), 0);
        check("t5_busy_off", 32'(bus_if.busy), 0);
        check("t5_ready", 32'(bus_if.cmd_ready), 1);
        @(posedge pclk);
        #1;
        check("t5_arb_pulse", 32'(bus_if.arb_lost), 0);
        check("t5_rsp_pulse", 32'(bus_if.rsp_valid), 0);
        xfer_wr = 1'b0;
        arb_en  = 1'b0;
        repeat (4) @(posedge pclk);
        #1;

        // WRITE without bus ownership.
        issue("t6_wr", OP_WRITE, 8'h33, 1'b0);
        check("t6_rsp", 32'(bus_if.rsp_valid), 1);
        check("t6_err", 32'(bus_if.rsp_err), 1);
        check("t6_lines", 32'({bus_if.scl_oe, bus_if.sda_oe}), 0);
        check("t6_busy", 32'(bus_if.busy), 0);
        @(posedge pclk);
        #1;
        check("t6_err_pulse", 32'(bus_if.rsp_err), 0);

        // Asynchronous reset in the middle of a READ.
        do_cmd("t7_start", OP_START, 16);
        slv_byte = 8'hC3;
        issue("t7_rd", OP_READ, 8'h00, 1'b0);
        xfer_rd = 1'b1;
        repeat (50) @(posedge pclk);
        #1;
        check("t7_pre_scl", 32'(bus_if.scl_oe), 1);
        check("t7_pre_rdata", 32'(bus_if.rsp_rdata), 32'h3C);
        #2;
        presetn = 1'b0;
        #1;
        check_reset_vals("t7_arst");
        xfer_rd = 1'b0;
        #3;
        presetn = 1'b1;
        repeat (2) @(posedge pclk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
